// File: rtl/sort_mem_if.sv
// Bus bundle for sort_mem: AR/R read channels and AW/W/B write channels.
// The master drives valid and payload, and the slave (sort_mem) drives the ready and response signals.
interface sort_mem_if #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
);
  logic                 ar_valid;
  logic                 ar_ready;
  logic [ADDR_WDTH-1:0] ar_address;
  logic                 r_valid;
  logic                 r_ready;
  logic [DATA_WDTH-1:0] r_data;
  logic [RESP_WDTH-1:0] r_resp;
  logic                 aw_valid;
  logic                 aw_ready;
  logic [ADDR_WDTH-1:0] aw_address;
  logic                 w_valid;
  logic                 w_ready;
  logic [DATA_WDTH-1:0] w_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [RESP_WDTH-1:0] b_resp;

  modport master (
    output ar_valid, ar_address, r_ready,
    output aw_valid, aw_address, w_valid, w_data, b_ready,
    input  ar_ready, r_valid, r_data, r_resp,
    input  aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  ar_valid, ar_address, r_ready,
    input  aw_valid, aw_address, w_valid, w_data, b_ready,
    output ar_ready, r_valid, r_data, r_resp,
    output aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/sort_mem.sv
// sort_mem: a register-file memory for the sort datapath, with independent read and write handshake FSMs.
// Defining SORT_MEM_BOUNDS_CHECK_EN turns on address range checking: out-of-range accesses return resp=1.
module sort_mem #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1,
  parameter int MEM_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  sort_mem_if.slave  bus
);

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOT_AW,
    W_GOT_W,
    W_RESP
  } w_state_e;

  localparam logic [RESP_WDTH-1:0] RESP_OK  = '0;
  localparam logic [RESP_WDTH-1:0] RESP_ERR = RESP_WDTH'(1);

  logic [DATA_WDTH-1:0] mem_q [MEM_DEPTH];

  r_state_e             r_state_q, r_state_d;
  logic [DATA_WDTH-1:0] r_data_q,  r_data_d;
  logic [RESP_WDTH-1:0] r_resp_q,  r_resp_d;

  w_state_e             w_state_q, w_state_d;
  logic [ADDR_WDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WDTH-1:0] w_data_q,  w_data_d;
  logic [RESP_WDTH-1:0] b_resp_q,  b_resp_d;

  logic [ADDR_WDTH-1:0] wr_addr;
  logic [DATA_WDTH-1:0] wr_data;
  logic                 wr_commit;
  logic                 rd_in_range;
  logic                 wr_in_range;

  // A committing write combines an address and data that each come either from the bus or from the value latched earlier.
  assign wr_addr = (w_state_q == W_GOT_AW) ? aw_addr_q : bus.aw_address;
  assign wr_data = (w_state_q == W_GOT_W)  ? w_data_q  : bus.w_data;

`ifdef SORT_MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_WDTH:0] DEPTH_LIM = (ADDR_WDTH+1)'(MEM_DEPTH);
  assign rd_in_range = ({1'b0, bus.ar_address} < DEPTH_LIM);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
`else
  assign rd_in_range = 1'b1;
  assign wr_in_range = 1'b1;
`endif

  // Read FSM: ar_ready is 1 in R_IDLE, so ar_valid alone marks an AR handshake there.
  always_comb begin
    // NOTE: every signal gets its default first, so no branch leaves one unassigned and no latch is inferred.
    r_state_d = r_state_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (bus.ar_valid) begin
          r_state_d = R_RESP;
          if (rd_in_range) begin
            r_data_d = mem_q[bus.ar_address];
            r_resp_d = RESP_OK;
          end else begin
            r_data_d = '0;
            r_resp_d = RESP_ERR;
          end
        end
      end
      R_RESP: if (bus.r_ready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM: the ready signals are high in every state where valid is checked, so valid equals handshake.
  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    b_resp_d  = b_resp_q;
    wr_commit = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (bus.aw_valid && bus.w_valid) begin
          wr_commit = 1'b1;
          w_state_d = W_RESP;
        end else if (bus.aw_valid) begin
          aw_addr_d = bus.aw_address;
          w_state_d = W_GOT_AW;
        end else if (bus.w_valid) begin
          w_data_d  = bus.w_data;
          w_state_d = W_GOT_W;
        end
      end
      W_GOT_AW: if (bus.w_valid) begin
        wr_commit = 1'b1;
        w_state_d = W_RESP;
      end
      W_GOT_W: if (bus.aw_valid) begin
        wr_commit = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: if (bus.b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    if (wr_commit) b_resp_d = wr_in_range ? RESP_OK : RESP_ERR;
  end

  // NOTE: all state uses non-blocking assignments, so a read sampled on the same edge as a write sees the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OK;
      w_state_q <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      b_resp_q  <= RESP_OK;
    end else begin
      r_state_q <= r_state_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      w_state_q <= w_state_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      b_resp_q  <= b_resp_d;
    end
  end

  // NOTE: the array must read back as zero after reset, so it is built from reset flops instead of an inferred RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_commit && wr_in_range) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign bus.ar_ready = (r_state_q == R_IDLE);
  assign bus.r_valid  = (r_state_q == R_RESP);
  assign bus.r_data   = r_data_q;
  assign bus.r_resp   = r_resp_q;
  assign bus.aw_ready = (w_state_q == W_IDLE) || (w_state_q == W_GOT_W);
  assign bus.w_ready  = (w_state_q == W_IDLE) || (w_state_q == W_GOT_AW);
  assign bus.b_valid  = (w_state_q == W_RESP);
  assign bus.b_resp   = b_resp_q;

endmodule

// File: tb/tb_sort_mem.sv
// Directed self-checking bench for sort_mem. The test steps run in a straight line with hand-computed expectations.
// If SORT_MEM_BOUNDS_CHECK_EN is defined, the bench builds the DUT with MEM_DEPTH=10 and also runs the out-of-range steps.
module tb_sort_mem;

`ifdef SORT_MEM_BOUNDS_CHECK_EN
  localparam int TB_DEPTH = 10;
`else
  localparam int TB_DEPTH = 16;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sort_mem_if #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) bus ();

  sort_mem #(
    .ADDR_WDTH(4),
    .DATA_WDTH(32),
    .RESP_WDTH(1),
    .MEM_DEPTH(TB_DEPTH)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single read with immediate consumption of the response.
  task automatic do_read(input logic [3:0] a, input logic [31:0] d, input logic er, input string tag);
    bus.ar_valid   = 1'b1;
    bus.ar_address = a;
    check({tag, ".ar_ready"}, 32'(bus.ar_ready), 32'd1);
    step();
    bus.ar_valid = 1'b0;
    check({tag, ".r_valid"}, 32'(bus.r_valid), 32'd1);
    check({tag, ".r_data"},  bus.r_data, d);
    check({tag, ".r_resp"},  32'(bus.r_resp), 32'(er));
    bus.r_ready = 1'b1;
    step();
    bus.r_ready = 1'b0;
    check({tag, ".r_done"}, 32'(bus.r_valid), 32'd0);
  endtask

  // AW and W presented in the same cycle, with the B response consumed immediately.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic er, input string tag);
    bus.aw_valid   = 1'b1;
    bus.aw_address = a;
    bus.w_valid    = 1'b1;
    bus.w_data     = d;
    step();
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    check({tag, ".b_valid"}, 32'(bus.b_valid), 32'd1);
    check({tag, ".b_resp"},  32'(bus.b_resp), 32'(er));
    check({tag, ".aw_ready"}, 32'(bus.aw_ready), 32'd0);
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
    check({tag, ".b_done"}, 32'(bus.b_valid), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.ar_valid   = 1'b0;
    bus.ar_address = '0;
    bus.r_ready    = 1'b0;
    bus.aw_valid   = 1'b0;
    bus.aw_address = '0;
    bus.w_valid    = 1'b0;
    bus.w_data     = '0;
    bus.b_ready    = 1'b0;
    repeat (2) step();

    check("rst.ar_ready", 32'(bus.ar_ready), 32'd1);
    check("rst.aw_ready", 32'(bus.aw_ready), 32'd1);
    check("rst.w_ready",  32'(bus.w_ready),  32'd1);
    check("rst.r_valid",  32'(bus.r_valid),  32'd0);
    check("rst.b_valid",  32'(bus.b_valid),  32'd0);
    check("rst.r_data",   bus.r_data,        32'd0);
    check("rst.r_resp",   32'(bus.r_resp),   32'd0);
    check("rst.b_resp",   32'(bus.b_resp),   32'd0);
    rst_n = 1'b1;
    step();

    do_read(4'd5, 32'h0, 1'b0, "rd5_after_reset");

    do_write(4'd3, 32'hDEADBEEF, 1'b0, "wr3");
    do_read(4'd3, 32'hDEADBEEF, 1'b0, "rd3");

    // W arrives two cycles ahead of AW.
    bus.w_valid = 1'b1;
    bus.w_data  = 32'h11;
    step();
    bus.w_valid = 1'b0;
    check("wfirst.w_ready_c1",  32'(bus.w_ready),  32'd0);
    check("wfirst.aw_ready_c1", 32'(bus.aw_ready), 32'd1);
    check("wfirst.b_valid_c1",  32'(bus.b_valid),  32'd0);
    step();
    check("wfirst.w_ready_c2",  32'(bus.w_ready),  32'd0);
    check("wfirst.b_valid_c2",  32'(bus.b_valid),  32'd0);
    bus.aw_valid   = 1'b1;
    bus.aw_address = 4'd7;
    step();
    bus.aw_valid = 1'b0;
    check("wfirst.b_valid", 32'(bus.b_valid), 32'd1);
    check("wfirst.b_resp",  32'(bus.b_resp),  32'd0);
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
    check("wfirst.w_ready_after", 32'(bus.w_ready), 32'd1);
    do_read(4'd7, 32'h11, 1'b0, "rd7");

    // AW arrives one cycle ahead of W.
    bus.aw_valid   = 1'b1;
    bus.aw_address = 4'd9;
    step();
    bus.aw_valid = 1'b0;
    check("awfirst.aw_ready", 32'(bus.aw_ready), 32'd0);
    check("awfirst.w_ready",  32'(bus.w_ready),  32'd1);
    bus.w_valid = 1'b1;
    bus.w_data  = 32'h99;
    step();
    bus.w_valid = 1'b0;
    check("awfirst.b_valid", 32'(bus.b_valid), 32'd1);
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
    do_read(4'd9, 32'h99, 1'b0, "rd9");

    // Read of addr 3 and write of 0x44 to addr 4, with both responses held for 4 cycles.
    bus.ar_valid   = 1'b1;
    bus.ar_address = 4'd3;
    bus.aw_valid   = 1'b1;
    bus.aw_address = 4'd4;
    bus.w_valid    = 1'b1;
    bus.w_data     = 32'h44;
    step();
    bus.ar_valid = 1'b0;
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall.r_valid",  32'(bus.r_valid),  32'd1);
      check("stall.r_data",   bus.r_data,        32'hDEADBEEF);
      check("stall.r_resp",   32'(bus.r_resp),   32'd0);
      check("stall.ar_ready", 32'(bus.ar_ready), 32'd0);
      check("stall.b_valid",  32'(bus.b_valid),  32'd1);
      check("stall.b_resp",   32'(bus.b_resp),   32'd0);
      check("stall.aw_ready", 32'(bus.aw_ready), 32'd0);
      step();
    end
    // The new AR is presented on the release edge, but the DUT must not accept it until the following edge.
    bus.r_ready    = 1'b1;
    bus.b_ready    = 1'b1;
    bus.ar_valid   = 1'b1;
    bus.ar_address = 4'd4;
    step();
    bus.r_ready = 1'b0;
    bus.b_ready = 1'b0;
    check("release.r_valid",  32'(bus.r_valid),  32'd0);
    check("release.ar_ready", 32'(bus.ar_ready), 32'd1);
    check("release.b_valid",  32'(bus.b_valid),  32'd0);
    check("release.aw_ready", 32'(bus.aw_ready), 32'd1);
    step();
    bus.ar_valid = 1'b0;
    check("rd4.r_valid", 32'(bus.r_valid), 32'd1);
    check("rd4.r_data",  bus.r_data,       32'h44);
    bus.r_ready = 1'b1;
    step();
    bus.r_ready = 1'b0;

    // Read and write of addr 2 commit on the same edge, and the read must return the old value.
    do_write(4'd2, 32'h5, 1'b0, "wr2_old");
    bus.ar_valid   = 1'b1;
    bus.ar_address = 4'd2;
    bus.aw_valid   = 1'b1;
    bus.aw_address = 4'd2;
    bus.w_valid    = 1'b1;
    bus.w_data     = 32'h22;
    step();
    bus.ar_valid = 1'b0;
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    check("sameedge.r_data",  bus.r_data,       32'h5);
    check("sameedge.b_valid", 32'(bus.b_valid), 32'd1);
    bus.r_ready = 1'b1;
    bus.b_ready = 1'b1;
    step();
    bus.r_ready = 1'b0;
    bus.b_ready = 1'b0;
    do_read(4'd2, 32'h22, 1'b0, "rd2_new");

    // Reset mid-transaction: the write to addr 6 has its AW latched and its W on the reset edge, and a read response is pending.
    bus.aw_valid   = 1'b1;
    bus.aw_address = 4'd6;
    bus.ar_valid   = 1'b1;
    bus.ar_address = 4'd3;
    step();
    bus.aw_valid = 1'b0;
    bus.ar_valid = 1'b0;
    check("midrst.r_pending", 32'(bus.r_valid), 32'd1);
    rst_n       = 1'b0;
    bus.w_valid = 1'b1;
    bus.w_data  = 32'h66;
    step();
    bus.w_valid = 1'b0;
    rst_n       = 1'b1;
    check("midrst.r_valid",  32'(bus.r_valid),  32'd0);
    check("midrst.b_valid",  32'(bus.b_valid),  32'd0);
    check("midrst.r_data",   bus.r_data,        32'd0);
    check("midrst.aw_ready", 32'(bus.aw_ready), 32'd1);
    check("midrst.w_ready",  32'(bus.w_ready),  32'd1);
    step();
    check("midrst.no_commit_b", 32'(bus.b_valid), 32'd0);
    do_read(4'd6, 32'h0, 1'b0, "rd6_aborted");
    do_read(4'd3, 32'h0, 1'b0, "rd3_cleared");

`ifdef SORT_MEM_BOUNDS_CHECK_EN
    do_write(4'd1, 32'hA5, 1'b0, "wr1_guard");
    do_write(4'd12, 32'hABCD, 1'b1, "wr12_oob");
    do_read(4'd12, 32'h0, 1'b1, "rd12_oob");
    do_read(4'd1, 32'hA5, 1'b0, "rd1_unchanged");
    do_read(4'd9, 32'h0, 1'b0, "rd9_unchanged");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sort_mem.md
SORT_MEM -- requirements
Module: sort_mem

Interface
REQ-001 Parameter ADDR_WDTH, default 4, SHALL be the word-address width.
REQ-002 Parameter DATA_WDTH, default 32, SHALL be the data word width.
REQ-003 Parameter RESP_WDTH, default 1, SHALL be the response width; value 0 = OK, 1 = error.
REQ-004 Parameter MEM_DEPTH, default 16, SHALL be the number of stored words, with MEM_DEPTH <= 2^ADDR_WDTH.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 Port list, as name, direction, width, meaning:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ar_valid  in  1  read address valid.
- ar_ready  out  1  read address accepted.
- ar_address  in  ADDR_WDTH  read word address.
- r_valid  out  1  read data valid.
- r_ready  in  1  read data consumed.
- r_data  out  DATA_WDTH  read data.
- r_resp  out  RESP_WDTH  read response.
- aw_valid  in  1  write address valid.
- aw_ready  out  1  write address accepted.
- aw_address  in  ADDR_WDTH  write word address.
- w_valid  in  1  write data valid.
- w_ready  out  1  write data accepted.
- w_data  in  DATA_WDTH  write data.
- b_valid  out  1  write response valid.
- b_ready  in  1  write response consumed.
- b_resp  out  RESP_WDTH  write response.

Function
REQ-007 The block SHALL store MEM_DEPTH words of DATA_WDTH bits and serve the sort datapath's array reads and writes.
REQ-008 A handshake SHALL occur on any channel in a cycle where valid and ready are both high; the source holds valid and payload stable until that handshake.
REQ-009 Read FSM states SHALL be R_IDLE (ar_ready=1, r_valid=0) and R_RESP (ar_ready=0, r_valid=1).
REQ-010 On an AR handshake in R_IDLE, the block SHALL sample the memory word at ar_address at that edge and enter R_RESP; r_valid is high in the next cycle, giving latency 1.
REQ-011 In R_RESP, r_data and r_resp SHALL be held stable until r_ready is high; the block then returns to R_IDLE and does not accept a new AR in that same cycle.
REQ-012 Write FSM states SHALL be W_IDLE (aw_ready=1, w_ready=1), W_GOT_AW (aw_ready=0, w_ready=1), W_GOT_W (aw_ready=1, w_ready=0) and W_RESP (aw_ready=0, w_ready=0, b_valid=1).
REQ-013 Write FSM transitions SHALL be:
- W_IDLE, AW and W handshakes in the same cycle: commit the write at that edge and go to W_RESP.
- W_IDLE, AW only: latch the address and go to W_GOT_AW.
- W_IDLE, W only: latch the data and go to W_GOT_W.
- W_GOT_AW on W handshake, or W_GOT_W on AW handshake: commit the write and go to W_RESP.
- W_RESP: hold b_valid/b_resp until b_ready is high, then go to W_IDLE.
REQ-014 The read and write FSMs SHALL operate independently and concurrently.
REQ-015 If a write commits on the same edge as an AR sample to the same address, the read SHALL return the pre-write value.
REQ-016 r_resp and b_resp SHALL be 0 whenever the macro in REQ-020 is absent.

Reset
REQ-017 While rst_n is low at a rising edge, both FSMs SHALL go to R_IDLE/W_IDLE and all memory words SHALL be cleared to 0.
REQ-018 Output values after reset SHALL be: ar_ready=1, aw_ready=1, w_ready=1, r_valid=0, b_valid=0, r_data=0, r_resp=0, b_resp=0.
REQ-019 A reset applied mid-transaction SHALL abort that transaction: no write is committed and any pending response is dropped.

Configuration
REQ-020 With SORT_MEM_BOUNDS_CHECK_EN defined:
- A read with address >= MEM_DEPTH SHALL return r_data=0, r_resp=1.
- A write with address >= MEM_DEPTH SHALL be discarded and return b_resp=1.
Without the macro, no bounds check is compiled in, MEM_DEPTH SHALL equal 2^ADDR_WDTH, and every address is valid.

Verification
REQ-021 After reset, read address 5 -> r_valid one cycle after the AR handshake with r_data=0, r_resp=0.
REQ-022 Write 0xDEADBEEF to address 3 with AW and W in the same cycle, then read address 3 -> b_resp=0 and r_data=0xDEADBEEF.
REQ-023 W presented two cycles before AW (address 7, data 0x11) -> FSM passes through W_GOT_W, w_ready is low until AW arrives, b_valid rises the cycle after the AW handshake, and a subsequent read of address 7 returns 0x11.
REQ-024 Hold r_ready=0 and b_ready=0 for 4 cycles -> r_data/r_resp and b_resp stay stable, and ar_ready/aw_ready stay 0 until the response is consumed.
REQ-025 Same-edge write of 0x22 and read of address 2 (old value 0x5) -> the read returns 0x5, and the next read returns 0x22.
REQ-026 With SORT_MEM_BOUNDS_CHECK_EN and MEM_DEPTH=10, write and read address 12 -> b_resp=1, r_resp=1, r_data=0, and no stored word changes.
